mdu_alu_sequencer: RTL and testbench

- Multi-cycle multiply/divide controller that time-shares the EX-stage 32-bit ALU.
- When idle, it passes the EX stage's ALU operands and opcode straight through to the ALU.
- When busy, it takes ownership of the ALU and drives ADD/SUB each cycle to iterate shift-add multiply or restoring divide.
- Results go into internal HI/LO registers, and the block raises busy so the hazard unit stalls the pipeline.

---
 rtl/mdu_alu_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_mdu_alu_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_alu_sequencer.sv
// Multi-cycle multiply/divide sequencer that borrows the shared EX-stage ALU while busy.
// Optional signed MULT/DIV support is enabled with the MDU_SIGNED_EN macro.
module mdu_alu_sequencer #(
    parameter int unsigned ITER   = 32,
    parameter logic [3:0]  OP_ADD = 4'b0000,
    parameter logic [3:0]  OP_SUB = 4'b0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic [31:0] ex_alu_a,
    input  logic [31:0] ex_alu_b,
    input  logic [3:0]  ex_alu_op,
    input  logic [31:0] alu_out,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    localparam int unsigned CntW = $clog2(ITER);

`ifdef MDU_SIGNED_EN
    typedef enum logic [2:0] {StIdle, StPre, StRun, StPost, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
`endif

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    // acc holds P_hi / remainder, shr holds P_lo / quotient, opnd holds multiplicand / divisor
    logic [31:0]     acc_q, acc_d, shr_q, shr_d, opnd_q, opnd_d;
    logic [31:0]     hi_q, hi_d, lo_q, lo_d;
    logic            is_div_q, is_div_d;
    logic [31:0]     mul_sum, div_s;
    logic            mul_carry, div_take;

`ifdef MDU_SIGNED_EN
    logic signed_q, signed_d, neg_rs_q, neg_rs_d, neg_rt_q, neg_rt_d;
    logic borrow_q, borrow_d, post_cnt_q, post_cnt_d;
`else
    logic unused_op_msb;
    assign unused_op_msb = op[1];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        shr_d     = shr_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        alu_a     = ex_alu_a;
        alu_b     = ex_alu_b;
        alu_op    = ex_alu_op;
        mul_sum   = acc_q;
        mul_carry = 1'b0;
        div_s     = {acc_q[30:0], shr_q[31]};
        div_take  = 1'b0;
`ifdef MDU_SIGNED_EN
        signed_d   = signed_q;
        neg_rs_d   = neg_rs_q;
        neg_rt_d   = neg_rt_q;
        borrow_d   = borrow_q;
        post_cnt_d = post_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    cnt_d    = '0;
                    acc_d    = '0;
                    is_div_d = op[0];
                    shr_d    = op[0] ? rs_val : rt_val;
                    opnd_d   = op[0] ? rt_val : rs_val;
                    state_d  = StRun;
`ifdef MDU_SIGNED_EN
                    signed_d   = op[1];
                    neg_rs_d   = op[1] & rs_val[31];
                    neg_rt_d   = op[1] & rt_val[31];
                    post_cnt_d = 1'b0;
                    if (op[1] & (rs_val[31] | rt_val[31])) state_d = StPre;
`endif
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
`ifdef MDU_SIGNED_EN
            StPre: begin
                // rs magnitude comes from the ALU; rt magnitude is formed locally in the same cycle
                alu_a  = '0;
                alu_b  = is_div_q ? shr_q : opnd_q;
                alu_op = OP_SUB;
                if (neg_rs_q) begin
                    if (is_div_q) shr_d = alu_out;
                    else          opnd_d = alu_out;
                end
                if (neg_rt_q) begin
                    if (is_div_q) opnd_d = ~opnd_q + 32'd1;
                    else          shr_d  = ~shr_q + 32'd1;
                end
                state_d = StRun;
            end
`endif
            StRun: begin
                cnt_d = cnt_q + CntW'(1);
                if (!is_div_q) begin
                    alu_a  = acc_q;
                    alu_b  = opnd_q;
                    alu_op = OP_ADD;
                    if (shr_q[0]) begin
                        mul_sum   = alu_out;
                        mul_carry = (alu_out < acc_q);
                    end
                    {acc_d, shr_d} = {mul_carry, mul_sum, shr_q[31:1]};
                end else begin
                    alu_a    = div_s;
                    alu_b    = opnd_q;
                    alu_op   = OP_SUB;
                    div_take = acc_q[31] | (div_s >= opnd_q);
                    acc_d    = div_take ? alu_out : div_s;
                    shr_d    = {shr_q[30:0], div_take};
                end
                if (cnt_q == CntW'(ITER - 1)) begin
`ifdef MDU_SIGNED_EN
                    state_d = signed_q ? StPost : StDone;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef MDU_SIGNED_EN
            StPost: begin
                alu_op     = OP_SUB;
                post_cnt_d = 1'b1;
                if (!post_cnt_q) begin
                    alu_a    = '0;
                    alu_b    = shr_q;
                    borrow_d = (shr_q != '0);
                    if (neg_rs_q ^ neg_rt_q) shr_d = alu_out;
                    if (is_div_q ? neg_rs_q : (neg_rs_q ^ neg_rt_q)) state_d = StPost;
                    else                                             state_d = StDone;
                end else begin
                    // high word: (0 - hi) or (-1 - hi) when the low word borrowed
                    alu_a   = (!is_div_q && borrow_q) ? '1 : '0;
                    alu_b   = acc_q;
                    acc_d   = alu_out;
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                hi_d    = acc_q;
                lo_d    = shr_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            shr_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
`ifdef MDU_SIGNED_EN
            signed_q   <= 1'b0;
            neg_rs_q   <= 1'b0;
            neg_rt_q   <= 1'b0;
            borrow_q   <= 1'b0;
            post_cnt_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            shr_q    <= shr_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
`ifdef MDU_SIGNED_EN
            signed_q   <= signed_d;
            neg_rs_q   <= neg_rs_d;
            neg_rt_q   <= neg_rt_d;
            borrow_q   <= borrow_d;
            post_cnt_q <= post_cnt_d;
`endif
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_mdu_alu_sequencer.sv
// Scoreboard bench for mdu_alu_sequencer: stimulus pushes expected HI/LO/busy length,
// a negedge monitor pops and compares whenever busy falls.
module tb_mdu_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we, busy;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val, wdata, ex_alu_a, ex_alu_b, alu_out, alu_a, alu_b, hi, lo;
    logic [3:0]  ex_alu_op, alu_op;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    // Reference ALU shared with the EX stage
    assign alu_out = (alu_op == 4'b0000) ? alu_a + alu_b :
                     (alu_op == 4'b0001) ? alu_a - alu_b : alu_a ^ alu_b;

    mdu_alu_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .ex_alu_a  (ex_alu_a),
        .ex_alu_b  (ex_alu_b),
        .ex_alu_op (ex_alu_op),
        .alu_out   (alu_out),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller must be just after a posedge with the DUT idle
    task automatic issue(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int len, input bit push);
        exp_t e;
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        if (push) begin
            e.name = name;
            e.hi   = ehi;
            e.lo   = elo;
            e.len  = len;
            sb_q.push_back(e);
        end
        tick();
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 80; i++) begin
            if (!busy) return;
            tick();
        end
        tests++;
        fails++;
        $display("FAIL %s_timeout: busy still %b after 80 cycles, required 0", name, busy);
    endtask

    // Monitor: compares the committed result on the cycle busy falls
    logic busy_prev = 1'b0;
    logic rst_prev  = 1'b0;
    int   busy_len  = 0;
    always @(negedge clk) begin
        exp_t e;
        if (busy) begin
            busy_len++;
        end else if (busy_prev) begin
            if (!rst_prev) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: result hi=%h lo=%h with no entry expected",
                             hi, lo);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_hi"}, hi, e.hi);
                    check({e.name, "_lo"}, lo, e.lo);
                    if (e.len > 0) check({e.name, "_busy_len"}, 32'(busy_len), 32'(e.len));
                end
            end
            busy_len = 0;
        end
        busy_prev = busy;
        rst_prev  = reset;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        ex_alu_a = '0; ex_alu_b = '0; ex_alu_op = '0;
        tick();
        tick();
        reset     = 1'b0;
        ex_alu_a  = 32'd5;
        ex_alu_b  = 32'd3;
        ex_alu_op = 4'b0001;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("pass_a", alu_a, 32'd5);
        check("pass_b", alu_b, 32'd3);
        check("pass_op", {28'd0, alu_op}, 32'd1);

        tick();
        issue("multu_max2", 2'b00, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, 33, 1'b1);
        wait_idle("multu_max2");

        // DIVU 100/7 while EX stage keeps changing its ALU request
        issue("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b1);
        for (int i = 0; i < 5; i++) begin
            ex_alu_op = 4'hA ^ 4'(i);
            ex_alu_a  = $urandom;
            ex_alu_b  = $urandom;
            @(negedge clk);
            check("run_alu_op", {28'd0, alu_op}, 32'd1);
            check("run_alu_b", alu_b, 32'd7);
            tick();
        end
        wait_idle("divu_100_7");

        // Divide by zero; MTHI during RUN must not disturb HI
        issue("divu_by0", 2'b01, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 33, 1'b1);
        repeat (5) tick();
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        tick();
        hi_we = 1'b0;
        @(negedge clk);
        check("run_hi_we_ignored", hi, 32'd2);
        wait_idle("divu_by0");

        // start wins over lo_we in the same cycle
        lo_we = 1'b1;
        wdata = 32'h5555_5555;
        issue("multu_3_4", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 33, 1'b1);
        @(negedge clk);
        check("start_drops_lo_we", lo, 32'hFFFF_FFFF);
        wait_idle("multu_3_4");

        issue("multu_2p32", 2'b00, 32'h1_0000, 32'h1_0000, 32'h1, 32'h0, 33, 1'b1);
        wait_idle("multu_2p32");
        issue("multu_ff_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 33, 1'b1);
        wait_idle("multu_ff_ff");
        issue("divu_ff_16", 2'b01, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 33, 1'b1);
        wait_idle("divu_ff_16");
        issue("divu_5_9", 2'b01, 32'd5, 32'd9, 32'd5, 32'd0, 33, 1'b1);
        wait_idle("divu_5_9");

`ifdef MDU_SIGNED_EN
        issue("mult_m3_5", 2'b10, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 36, 1'b1);
        wait_idle("mult_m3_5");
        issue("div_m7_2", 2'b11, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 36, 1'b1);
        wait_idle("div_m7_2");
`else
        issue("op10_as_multu", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 33,
              1'b1);
        wait_idle("op10_as_multu");
        issue("op11_as_divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b1);
        wait_idle("op11_as_divu");
`endif

        // MTHI/MTLO in IDLE
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hA5A5_A5A5;
        tick();
        hi_we = 1'b0;
        lo_we = 1'b0;
        @(negedge clk);
        check("mt_both_hi", hi, 32'hA5A5_A5A5);
        check("mt_both_lo", lo, 32'hA5A5_A5A5);
        tick();
        hi_we = 1'b1;
        wdata = 32'h1111_1111;
        tick();
        hi_we = 1'b0;
        @(negedge clk);
        check("mthi_only_hi", hi, 32'h1111_1111);
        check("mthi_only_lo", lo, 32'hA5A5_A5A5);

        // Reset ten cycles into RUN aborts the multiply
        tick();
        issue("abort", 2'b00, 32'd7, 32'd9, 32'd0, 32'd0, 0, 1'b0);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        ex_alu_a  = 32'h0BAD_F00D;
        ex_alu_b  = 32'h0000_0042;
        ex_alu_op = 4'b0110;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_pass_a", alu_a, 32'h0BAD_F00D);
        check("abort_pass_op", {28'd0, alu_op}, 32'd6);

        tick();
        issue("divu_bigd", 2'b01, 32'hFFFF_FFFE, 32'h8000_0001, 32'h7FFF_FFFD, 32'h1, 33, 1'b1);
        wait_idle("divu_bigd");

        repeat (3) tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
